// File: rtl/rx_block_lock_ctrl.sv
// Block-lock controller for the Rx 64b/66b path: watches sync headers, slips the
// block-sync datapath one bit at a time until alignment is found, then reports lock.
module rx_block_lock_ctrl #(
    parameter int HDR_WIDTH    = 2,
    parameter int GOOD_CNT_MAX = 64,
    parameter int BAD_CNT_MAX  = 16,
    parameter int SLIP_WAIT    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_hdr_valid,
    input  logic [HDR_WIDTH-1:0] i_hdr,
    output logic                 o_slip,
    output logic                 o_block_lock,
    output logic                 o_hdr_err
);

    localparam int SH_W   = $clog2(GOOD_CNT_MAX + 1);
    localparam int BAD_W  = $clog2(BAD_CNT_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_MAX    = SH_W'(GOOD_CNT_MAX);
    localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(BAD_CNT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    state_t              state_q;
    logic [SH_W-1:0]     sh_cnt_q;
    logic [SH_W-1:0]     sh_cnt_d;
    logic [BAD_W-1:0]    bad_cnt_q;
    logic [BAD_W-1:0]    bad_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    logic                slip_q;
    logic                lock_q;
    logic                hdr_err_q;
    logic                hdr_ok;

    // A sync header is valid only when its two bits differ (01 or 10).
    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
        return (hdr == HDR_WIDTH'(2'b01)) || (hdr == HDR_WIDTH'(2'b10));
    endfunction

    // Incremented / decremented counter values; all saturate so none can wrap.
    always_comb begin
        hdr_ok     = hdr_is_valid(i_hdr);
        sh_cnt_d   = (sh_cnt_q == SH_MAX)   ? SH_MAX  : sh_cnt_q + SH_W'(1);
        bad_cnt_d  = (bad_cnt_q == BAD_MAX) ? BAD_MAX : bad_cnt_q + BAD_W'(1);
        wait_cnt_d = (wait_cnt_q == '0)     ? '0      : wait_cnt_q - WAIT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_RESET_CNT;
            sh_cnt_q   <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            hdr_err_q  <= 1'b0;
        end else begin
            slip_q    <= 1'b0;
            hdr_err_q <= 1'b0;
            case (state_q)
                ST_RESET_CNT: begin
                    sh_cnt_q  <= '0;
                    bad_cnt_q <= '0;
                    state_q   <= ST_TEST_SH;
                end
                ST_TEST_SH: begin
                    if (i_hdr_valid) begin
                        sh_cnt_q <= sh_cnt_d;
                        if (hdr_ok) begin
                            if (sh_cnt_d == SH_MAX) begin
                                if (bad_cnt_q == '0) begin
                                    lock_q <= 1'b1;
                                end
                                state_q <= ST_RESET_CNT;
                            end
                        end else begin
                            bad_cnt_q <= bad_cnt_d;
                            hdr_err_q <= 1'b1;
                            // Slip wins over window completion on the same strobe.
                            if ((bad_cnt_d == BAD_MAX) || !lock_q) begin
                                state_q <= ST_SLIP;
                            end else if (sh_cnt_d == SH_MAX) begin
                                state_q <= ST_RESET_CNT;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    slip_q     <= 1'b1;
                    lock_q     <= 1'b0;
                    wait_cnt_q <= WAIT_LOAD;
                    state_q    <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    if (i_hdr_valid) begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == '0) begin
                            state_q <= ST_RESET_CNT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RESET_CNT;
                end
            endcase
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;
    assign o_hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// Bench for rx_block_lock_ctrl: directed steps plus randomized headers, checked
// every cycle against a window/slip reference model and a bit-serial 66b stream.
module tb_rx_block_lock_ctrl;

    localparam int GOOD = 64;
    localparam int BAD  = 16;
    localparam int SW   = 4;
    localparam int NBLK = 1200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hdr_valid = 1'b0;
    logic [1:0] hdr = 2'b00;
    logic       o_slip;
    logic       o_block_lock;
    logic       o_hdr_err;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int slip_seen = 0;
    bit gaps = 1'b0;

    // Reference model state: window counts, lock flag and the slip/realign schedule.
    int m_cnt, m_bad, m_wait;
    bit m_lock, m_restart, m_slip_due;
    bit exp_err, exp_slip;

    logic [1:0]  blk_hdr [NBLK];
    logic [63:0] blk_pay [NBLK];

    rx_block_lock_ctrl #(
        .HDR_WIDTH(2), .GOOD_CNT_MAX(GOOD), .BAD_CNT_MAX(BAD), .SLIP_WAIT(SW)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_hdr_valid(hdr_valid),
        .i_hdr(hdr),
        .o_slip(o_slip),
        .o_block_lock(o_block_lock),
        .o_hdr_err(o_hdr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_bad = 0; m_wait = 0;
        m_lock = 0; m_restart = 1; m_slip_due = 0;
        exp_err = 0; exp_slip = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] h);
        exp_err = 0;
        exp_slip = 0;
        if (m_slip_due) begin
            m_slip_due = 0; exp_slip = 1; m_lock = 0; m_wait = SW;
        end else if (m_wait > 0) begin
            if (v) begin
                m_wait--;
                if (m_wait == 0) m_restart = 1;
            end
        end else if (m_restart) begin
            m_restart = 0; m_cnt = 0; m_bad = 0;
        end else if (v) begin
            m_cnt++;
            if (h == 2'b01 || h == 2'b10) begin
                if (m_cnt == GOOD) begin
                    if (m_bad == 0) m_lock = 1;
                    m_restart = 1;
                end
            end else begin
                m_bad++;
                exp_err = 1;
                if (m_bad == BAD || !m_lock) m_slip_due = 1;
                else if (m_cnt == GOOD) m_restart = 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] h);
        hdr_valid = v;
        hdr = h;
        @(posedge clk);
        model_step(v, h);
        #1;
        chk("slip", o_slip, exp_slip);
        chk("lock", o_block_lock, m_lock);
        chk("hdr_err", o_hdr_err, exp_err);
        if (o_hdr_err) err_seen++;
        if (o_slip) slip_seen++;
    endtask

    task automatic strobe(input logic [1:0] h);
        if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 2'($urandom));
        step(1'b1, h);
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    endfunction

    // Called just after a check point; pulses reset between clock edges.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_slip"}, o_slip, 1'b0);
        chk({tag, "_lock"}, o_block_lock, 1'b0);
        chk({tag, "_err"}, o_hdr_err, 1'b0);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic sbit(input int idx);
        int b, k;
        b = idx / 66;
        k = idx % 66;
        if (b >= NBLK) return 1'b0;
        if (k < 2) return blk_hdr[b][k];
        return blk_pay[b][k-2];
    endfunction

    initial begin
        int e0, s0, placed, nbad, off, n, slips, post, p, blk;
        bit lock_seen;
        logic badpos [GOOD];
        logic [1:0] h;
        logic [31:0] lo, hi;

        model_reset();
        for (int i = 0; i < NBLK; i++) begin
            blk_hdr[i] = good_hdr();
            blk_pay[i] = {$urandom, $urandom};
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_slip", o_slip, 1'b0);
        chk("rst_lock", o_block_lock, 1'b0);
        chk("rst_err", o_hdr_err, 1'b0);
        rst_n = 1'b1;
        model_reset();

        // Unlocked: first header invalid -> hdr_err, then slip, then 4 ignored strobes.
        step(1'b0, 2'b00);
        step(1'b1, 2'b11);
        chk("unl_err", o_hdr_err, 1'b1);
        chk("unl_slip0", o_slip, 1'b0);
        step(1'b0, 2'b00);
        chk("unl_slip", o_slip, 1'b1);
        chk("unl_err_clr", o_hdr_err, 1'b0);
        for (int i = 0; i < SW; i++) begin
            step(1'b1, 2'b11);
            chk("unl_wait_ignored", o_hdr_err, 1'b0);
        end

        // Lock acquisition with alternating clean headers.
        s0 = slip_seen;
        step(1'b0, 2'b00);
        for (int i = 0; i < GOOD; i++) step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
        chk("acq_lock", o_block_lock, 1'b1);
        chk("acq_noslip", slip_seen - s0, 0);

        // Locked tolerance: 15 invalid headers in one window, then a clean window.
        gaps = 1'b1;
        for (int i = 0; i < GOOD; i++) badpos[i] = 1'b0;
        placed = 0;
        while (placed < BAD - 1) begin
            p = $urandom_range(0, GOOD - 1);
            if (!badpos[p]) begin badpos[p] = 1'b1; placed++; end
        end
        e0 = err_seen; s0 = slip_seen;
        step(1'b0, 2'b00);
        for (int i = 0; i < GOOD; i++) strobe(badpos[i] ? bad_hdr() : good_hdr());
        chk("tol_errs", err_seen - e0, BAD - 1);
        chk("tol_noslip", slip_seen - s0, 0);
        chk("tol_lock", o_block_lock, 1'b1);
        step(1'b0, 2'b00);
        for (int i = 0; i < GOOD; i++) strobe(good_hdr());
        chk("tol_clean_lock", o_block_lock, 1'b1);

        // Loss of lock: 16th invalid in a window forces a slip.
        gaps = 1'b0;
        for (int i = 0; i < GOOD; i++) badpos[i] = 1'b0;
        placed = 0;
        while (placed < BAD) begin
            p = $urandom_range(0, GOOD - 5);
            if (!badpos[p]) begin badpos[p] = 1'b1; placed++; end
        end
        step(1'b0, 2'b00);
        nbad = 0;
        for (int i = 0; i < GOOD && nbad < BAD; i++) begin
            if (badpos[i]) nbad++;
            step(1'b1, badpos[i] ? bad_hdr() : good_hdr());
        end
        chk("loss_err16", o_hdr_err, 1'b1);
        step(1'b1, good_hdr());
        chk("loss_slip", o_slip, 1'b1);
        chk("loss_lock", o_block_lock, 1'b0);
        for (int i = 0; i < SW + 1 + GOOD; i++) step(1'b1, good_hdr());
        chk("relock", o_block_lock, 1'b1);

        // Asynchronous reset while locked, mid-window.
        for (int i = 0; i < 10; i++) step(1'b1, good_hdr());
        chk("pre_rst_lock", o_block_lock, 1'b1);
        async_reset("arst_locked");

        // Asynchronous reset while the slip pulse is out.
        step(1'b0, 2'b00);
        step(1'b1, bad_hdr());
        step(1'b0, 2'b00);
        chk("pre_rst_slip", o_slip, 1'b1);
        async_reset("arst_wait");
        s0 = slip_seen;
        step(1'b0, 2'b00);
        for (int i = 0; i < GOOD; i++) step(1'b1, good_hdr());
        chk("arst_relock", o_block_lock, 1'b1);
        chk("arst_noslip", slip_seen - s0, 0);

        // Misaligned serial stream with the slip loop closed through the bench datapath.
        async_reset("arst_mis");
        off = $urandom_range(1, 65);
        n = 0; slips = 0; post = 0; lock_seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && post < 20; cyc++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 2'($urandom));
            end else begin
                p = n * 66 + off;
                h = {sbit(p + 1), sbit(p)};
                for (int j = 0; j < 32; j++) begin
                    lo[j] = sbit(p + 2 + j);
                    hi[j] = sbit(p + 34 + j);
                end
                if (lock_seen) begin
                    blk = n + off / 66;
                    chk("mis_hdr", h, blk_hdr[blk]);
                    chk("mis_lo", lo, blk_pay[blk][31:0]);
                    chk("mis_hi", hi, blk_pay[blk][63:32]);
                    post++;
                end
                step(1'b1, h);
                n++;
            end
            if (o_slip) begin off++; slips++; end
            if (o_block_lock && !lock_seen) begin
                lock_seen = 1'b1;
                chk("mis_align", off % 66, 0);
                chk("mis_slip_budget", slips <= 66, 1'b1);
            end
        end
        chk("mis_postlock_words", post, 20);
        chk("mis_lock_held", o_block_lock, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
